fft_in_framer: RTL and testbench

FFT_IN_FRAMER -- requirements
Module: fft_in_framer

---
 rtl/fft_in_framer_pkg.sv | 22 ++
 rtl/fft_in_framer_bank.sv | 36 +++
 rtl/fft_in_framer.sv | 204 ++++++++++++++++++++
 tb/tb_fft_in_framer.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_in_framer_pkg.sv
// Shared FFT front-end definitions: frame geometry and the framer state encodings.
package fft_in_framer_pkg;

    localparam int FFT_LEN = 16;
    localparam int FFT_N   = FFT_LEN;
    localparam int FFT_W   = 16;
    localparam int FFT_GAP = FFT_N / 2;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_BURST,
        RD_GAP
    } rd_state_e;

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL,
        BANK_READING
    } bank_state_e;

endpackage

// File: rtl/fft_in_framer_bank.sv
// One ping-pong bank: N entries of packed {re, im}, one write port, one registered read port.
module framer_bank
    import fft_in_framer_pkg::*;
#(
    parameter int N = FFT_N,
    parameter int W = FFT_W
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [$clog2(N)-1:0] waddr_i,
    input  logic [2*W-1:0]       wdata_i,
    input  logic                 re_i,
    input  logic [$clog2(N)-1:0] raddr_i,
    output logic [2*W-1:0]       rdata_o
);

    logic [2*W-1:0] mem_q [N];
    logic [2*W-1:0] rdata_q;

    // Sample storage; contents are never reset, stale data is simply overwritten.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read so the data lines up one cycle after the address is issued.
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_in_framer.sv
// Ping-pong input framer: gathers N-sample frames and streams each as one contiguous burst
// into the FFT, with at least GAP idle cycles between bursts.
module fft_in_framer
    import fft_in_framer_pkg::*;
#(
    parameter int N   = FFT_N,
    parameter int W   = FFT_W,
    parameter int GAP = FFT_GAP
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_re,
    input  logic [W-1:0] s_im,
    output logic         m_stb,
    output logic         m_sop,
    output logic [W-1:0] m_re,
    output logic [W-1:0] m_im,
    output logic         overflow
);

    localparam int AW = $clog2(N);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    bank_state_e   bank_q [2];
    bank_state_e   bank_d [2];
    logic          wr_bank_q, wr_bank_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic          s_ready_q, s_ready_d;
    logic          overflow_q;

    rd_state_e     rd_state_q;
    logic          rd_bank_q;
    logic [AW-1:0] rd_addr_q;
    logic [GW-1:0] gap_cnt_q;

    logic          pipe_vld_q, pipe_sop_q, pipe_bank_q;
    logic          m_stb_q, m_sop_q;
    logic [W-1:0]  m_re_q, m_im_q;

    logic          accept, wr_last, rd_full, gap_done;
    logic          claim_idle, claim_gap, release_bank, issue;
    logic [AW-1:0] issue_addr;
    logic [2*W-1:0] rdata [2];

    assign accept       = s_valid & s_ready_q & ~flush;
    assign wr_last      = (wr_addr_q == AW'(N - 1));
    assign rd_full      = (bank_q[rd_bank_q] == BANK_FULL);
    assign gap_done     = (gap_cnt_q == GW'(GAP - 1));
    assign claim_idle   = (rd_state_q == RD_IDLE) & rd_full;
    assign claim_gap    = (rd_state_q == RD_GAP) & gap_done & rd_full;
    assign release_bank = (rd_state_q == RD_BURST) & (rd_addr_q == AW'(N - 1));
    assign issue        = claim_idle | (rd_state_q == RD_BURST);
    assign issue_addr   = claim_idle ? '0 : rd_addr_q;

    // Bank ownership and write pointer; s_ready looks ahead at the bank the writer will target next.
    always_comb begin
        bank_d[0] = bank_q[0];
        bank_d[1] = bank_q[1];
        wr_bank_d = wr_bank_q;
        wr_addr_d = wr_addr_q;
        if (flush) begin
            bank_d[0] = BANK_EMPTY;
            bank_d[1] = BANK_EMPTY;
            wr_bank_d = 1'b0;
            wr_addr_d = '0;
        end else begin
            if (claim_idle | claim_gap) begin
                bank_d[rd_bank_q] = BANK_READING;
            end
            if (release_bank) begin
                bank_d[rd_bank_q] = BANK_EMPTY;
            end
            if (accept) begin
                if (wr_last) begin
                    bank_d[wr_bank_q] = BANK_FULL;
                    wr_bank_d         = ~wr_bank_q;
                    wr_addr_d         = '0;
                end else begin
                    bank_d[wr_bank_q] = BANK_FILLING;
                    wr_addr_d         = wr_addr_q + AW'(1);
                end
            end
        end
        s_ready_d = (bank_d[wr_bank_d] == BANK_EMPTY) || (bank_d[wr_bank_d] == BANK_FILLING);
    end

    // Write-side state, registered ready and the sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_q[0]  <= BANK_EMPTY;
            bank_q[1]  <= BANK_EMPTY;
            wr_bank_q  <= 1'b0;
            wr_addr_q  <= '0;
            s_ready_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            bank_q[0] <= bank_d[0];
            bank_q[1] <= bank_d[1];
            wr_bank_q <= wr_bank_d;
            wr_addr_q <= wr_addr_d;
            s_ready_q <= s_ready_d;
            if (flush) begin
                overflow_q <= 1'b0;
            end else if (s_valid && !s_ready_q) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Read FSM: claim a full bank, sweep its N addresses, then hold off for GAP cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state_q <= RD_IDLE;
            rd_bank_q  <= 1'b0;
            rd_addr_q  <= '0;
            gap_cnt_q  <= '0;
        end else if (flush) begin
            rd_state_q <= RD_IDLE;
            rd_bank_q  <= 1'b0;
            rd_addr_q  <= '0;
            gap_cnt_q  <= '0;
        end else begin
            case (rd_state_q)
                RD_IDLE: begin
                    if (claim_idle) begin
                        rd_state_q <= RD_BURST;
                        rd_addr_q  <= AW'(1);
                    end
                end
                RD_BURST: begin
                    if (release_bank) begin
                        rd_state_q <= RD_GAP;
                        rd_bank_q  <= ~rd_bank_q;
                        rd_addr_q  <= '0;
                        gap_cnt_q  <= '0;
                    end else begin
                        rd_addr_q <= rd_addr_q + AW'(1);
                    end
                end
                RD_GAP: begin
                    if (gap_done) begin
                        rd_state_q <= claim_gap ? RD_BURST : RD_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GW'(1);
                    end
                end
                default: rd_state_q <= RD_IDLE;
            endcase
        end
    end

    // Output pipeline: one stage tracks the RAM read, the next registers the FFT-facing signals.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_vld_q  <= 1'b0;
            pipe_sop_q  <= 1'b0;
            pipe_bank_q <= 1'b0;
            m_stb_q     <= 1'b0;
            m_sop_q     <= 1'b0;
            m_re_q      <= '0;
            m_im_q      <= '0;
        end else if (flush) begin
            pipe_vld_q <= 1'b0;
            pipe_sop_q <= 1'b0;
            m_stb_q    <= 1'b0;
            m_sop_q    <= 1'b0;
        end else begin
            pipe_vld_q  <= issue;
            pipe_sop_q  <= issue & (issue_addr == '0);
            pipe_bank_q <= rd_bank_q;
            m_stb_q     <= pipe_vld_q;
            m_sop_q     <= pipe_sop_q;
            if (pipe_vld_q) begin
                {m_re_q, m_im_q} <= rdata[pipe_bank_q];
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        framer_bank #(
            .N(N),
            .W(W)
        ) u_bank (
            .clk_i  (clk),
            .we_i   (accept && (wr_bank_q == 1'(b))),
            .waddr_i(wr_addr_q),
            .wdata_i({s_re, s_im}),
            .re_i   (issue && (rd_bank_q == 1'(b))),
            .raddr_i(issue_addr),
            .rdata_o(rdata[b])
        );
    end

    assign s_ready  = s_ready_q;
    assign overflow = overflow_q;
    assign m_stb    = m_stb_q;
    assign m_sop    = m_sop_q;
    assign m_re     = m_re_q;
    assign m_im     = m_im_q;

endmodule

// File: tb/tb_fft_in_framer.sv
// Scoreboard bench for fft_in_framer: accepted samples are queued, bursts are popped and checked.
module tb_fft_in_framer;

    localparam int N   = 16;
    localparam int W   = 16;
    localparam int GAP = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [W-1:0] s_re = '0;
    logic [W-1:0] s_im = '0;
    logic         m_stb, m_sop, overflow;
    logic [W-1:0] m_re, m_im;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int run_len = 0;
    logic [2*W-1:0] exp_q [$];
    logic [2*W-1:0] exp_val;
    int starts_q [$];

    fft_in_framer #(
        .N  (N),
        .W  (W),
        .GAP(GAP)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_re    (s_re),
        .s_im    (s_im),
        .m_stb   (m_stb),
        .m_sop   (m_sop),
        .m_re    (m_re),
        .m_im    (m_im),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Scoreboard monitor on the falling edge: pop and compare output, then record this cycle's accept.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            starts_q.delete();
            run_len = 0;
        end else begin
            if (m_stb) begin
                if (run_len == 0) begin
                    if (starts_q.size() > 0) begin
                        tests_run++;
                        if (cyc - starts_q[$] < N + GAP) begin
                            tests_failed++;
                            $display("[TB] FAIL frame_spacing: got %0d cycles, need >= %0d", cyc - starts_q[$], N + GAP);
                        end
                    end
                    starts_q.push_back(cyc);
                end
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("[TB] FAIL out_data: got re=%h im=%h, expected no sample", m_re, m_im);
                end else begin
                    exp_val = exp_q.pop_front();
                    if ({m_re, m_im} !== exp_val) begin
                        tests_failed++;
                        $display("[TB] FAIL out_data: got re=%h im=%h, expected re=%h im=%h",
                                 m_re, m_im, exp_val[2*W-1:W], exp_val[W-1:0]);
                    end
                end
                tests_run++;
                if (m_sop !== (run_len == 0)) begin
                    tests_failed++;
                    $display("[TB] FAIL sop: got %b at burst index %0d", m_sop, run_len);
                end
                run_len++;
            end else begin
                if (run_len != 0) begin
                    tests_run++;
                    if (run_len != N) begin
                        tests_failed++;
                        $display("[TB] FAIL burst_len: got %0d, expected %0d", run_len, N);
                    end
                    run_len = 0;
                end
                tests_run++;
                if (m_sop !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL sop_idle: got %b with m_stb low, expected 0", m_sop);
                end
            end
            if (flush) begin
                exp_q.delete();
                starts_q.delete();
                run_len = 0;
            end
            if (s_valid && s_ready && !flush) begin
                exp_q.push_back({s_re, s_im});
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Handshake-aware send: waits for s_ready, transfers one sample, returns the accept cycle.
    task automatic send(input logic [W-1:0] re, input logic [W-1:0] im, output int acc_cyc);
        int n;
        n = 0;
        acc_cyc = -1;
        while (!s_ready && n < 500) begin
            s_valid = 1'b0;
            tick();
            n++;
        end
        if (n >= 500) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL send_timeout: s_ready stayed 0, expected 1");
        end else begin
            s_valid = 1'b1;
            s_re    = re;
            s_im    = im;
            tick();
            acc_cyc = cyc;
            s_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_stb) && n < 400) begin
            tick();
            n++;
        end
        tests_run++;
        if (n >= 400) begin
            tests_failed++;
            $display("[TB] FAIL drain_timeout: %0d samples pending, expected 0", exp_q.size());
        end
        repeat (GAP + 4) tick();
    endtask

    task automatic wait_stb(output int seen);
        int n;
        n = 0;
        seen = -1;
        while (seen < 0 && n < 80) begin
            @(negedge clk);
            if (m_stb) seen = cyc;
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++; if (s_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_s_ready: got %b, expected 0", s_ready); end
        tests_run++; if (m_stb !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_m_stb: got %b, expected 0", m_stb); end
        tests_run++; if (m_sop !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_m_sop: got %b, expected 0", m_sop); end
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_overflow: got %b, expected 0", overflow); end
        tests_run++; if ({m_re, m_im} !== '0) begin tests_failed++; $display("[TB] FAIL reset_m_data: got %h, expected 0", {m_re, m_im}); end
        tick();
        rst = 1'b0;
        @(negedge clk);
        tests_run++; if (s_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL ready_before_edge: got %b, expected 0", s_ready); end
        @(negedge clk);
        tests_run++; if (s_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL ready_after_reset: got %b, expected 1", s_ready); end
        tick();
    endtask

    task automatic test_single_frame();
        int last_acc, first_stb;
        starts_q.delete();
        for (int k = 0; k < N; k++) send(W'(k), W'(-k), last_acc);
        wait_stb(first_stb);
        tests_run++;
        if (first_stb - last_acc != 2) begin
            tests_failed++;
            $display("[TB] FAIL first_latency: got %0d cycles, expected 2", first_stb - last_acc);
        end
        tests_run++;
        if (m_sop !== 1'b1 || m_re !== '0) begin
            tests_failed++;
            $display("[TB] FAIL first_sample: got sop=%b re=%h, expected sop=1 re=0000", m_sop, m_re);
        end
        tick();
        wait_idle();
        tests_run++;
        if (starts_q.size() != 1) begin
            tests_failed++;
            $display("[TB] FAIL single_burst_count: got %0d, expected 1", starts_q.size());
        end
    endtask

    task automatic test_pingpong();
        int last_acc;
        starts_q.delete();
        for (int k = 0; k < 3 * N; k++) send(W'(k), W'(k + 1000), last_acc);
        @(negedge clk);
        tests_run++;
        if (s_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL pingpong_full_ready: got %b, expected 0", s_ready);
        end
        tick();
        wait_idle();
        tests_run++;
        if (starts_q.size() != 3) begin
            tests_failed++;
            $display("[TB] FAIL pingpong_bursts: got %0d, expected 3", starts_q.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                tests_run++;
                if (starts_q[i] - starts_q[i-1] != N + GAP) begin
                    tests_failed++;
                    $display("[TB] FAIL pingpong_spacing: got %0d, expected %0d", starts_q[i] - starts_q[i-1], N + GAP);
                end
            end
        end
        tests_run++;
        if (overflow !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL pingpong_overflow: got %b, expected 0", overflow);
        end
    endtask

    task automatic test_overflow();
        s_valid = 1'b1;
        for (int i = 0; i < 3 * N + 8; i++) begin
            s_re = W'(i + 2000);
            s_im = W'(i + 3000);
            tick();
        end
        s_valid = 1'b0;
        @(negedge clk);
        tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("[TB] FAIL overflow_set: got %b, expected 1", overflow); end
        repeat (5) tick();
        @(negedge clk);
        tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("[TB] FAIL overflow_sticky: got %b, expected 1", overflow); end
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("[TB] FAIL overflow_clear: got %b, expected 0", overflow); end
        tests_run++; if (m_stb !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush_stb: got %b, expected 0", m_stb); end
        tests_run++; if (s_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL flush_ready: got %b, expected 1", s_ready); end
        tick();
        wait_idle();
    endtask

    task automatic test_flush_burst();
        int last_acc, seen;
        for (int k = 0; k < N; k++) send(W'(k + 500), W'(k + 600), last_acc);
        wait_stb(seen);
        tests_run++;
        if (seen < 0 || m_sop !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL flush_burst_start: got stb_cycle=%0d sop=%b, expected a burst start", seen, m_sop);
        end
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        tests_run++;
        if (m_re !== W'(505)) begin
            tests_failed++;
            $display("[TB] FAIL flush_addr5: got re=%h, expected %h", m_re, W'(505));
        end
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        tests_run++; if (m_stb !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush_trunc_stb: got %b, expected 0", m_stb); end
        tests_run++; if (m_re !== W'(505)) begin tests_failed++; $display("[TB] FAIL flush_hold_re: got %h, expected %h", m_re, W'(505)); end
        tick();
        for (int k = 0; k < N; k++) send(W'(k + 700), W'(k + 750), last_acc);
        wait_stb(seen);
        tests_run++;
        if (m_sop !== 1'b1 || m_re !== W'(700)) begin
            tests_failed++;
            $display("[TB] FAIL post_flush_frame: got sop=%b re=%h, expected sop=1 re=%h", m_sop, m_re, W'(700));
        end
        tick();
        wait_idle();
    endtask

    task automatic test_reset_midfill();
        int last_acc, seen;
        for (int k = 0; k < 7; k++) send(W'(k + 800), W'(k + 900), last_acc);
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({s_ready, m_stb, m_sop, overflow} !== 4'b0 || {m_re, m_im} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL midfill_reset_outputs: got ready=%b stb=%b sop=%b ovf=%b data=%h, expected all 0",
                     s_ready, m_stb, m_sop, overflow, {m_re, m_im});
        end
        tick();
        rst = 1'b0;
        for (int k = 0; k < N; k++) send(W'(k + 1000), W'(k + 1100), last_acc);
        wait_stb(seen);
        tests_run++;
        if (m_sop !== 1'b1 || m_re !== W'(1000) || m_im !== W'(1100)) begin
            tests_failed++;
            $display("[TB] FAIL midfill_residue: got sop=%b re=%h im=%h, expected sop=1 re=%h im=%h",
                     m_sop, m_re, m_im, W'(1000), W'(1100));
        end
        tick();
        wait_idle();
    endtask

    task automatic test_random();
        int acc, n;
        starts_q.delete();
        acc = 0;
        n = 0;
        while (acc < 10 * N && n < 5000) begin
            s_valid = 1'($urandom_range(0, 1));
            s_re    = W'($urandom);
            s_im    = W'($urandom);
            if (s_valid && s_ready) acc++;
            tick();
            n++;
        end
        s_valid = 1'b0;
        tests_run++;
        if (acc != 10 * N) begin
            tests_failed++;
            $display("[TB] FAIL random_accepts: got %0d, expected %0d", acc, 10 * N);
        end
        wait_idle();
        tests_run++;
        if (starts_q.size() != 10) begin
            tests_failed++;
            $display("[TB] FAIL random_bursts: got %0d, expected 10", starts_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_pingpong();
        test_overflow();
        test_flush_burst();
        test_reset_midfill();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
